// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/MEM single-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned TIMEOUT_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;

  // A disabled timeout still needs a 1-bit counter to keep the port legal.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_timer.sv
// Bus wait-state counter; expired flags the last permitted wait cycle.
module arb_timer
  import mem_arb_pkg::*;
#(
  parameter  int unsigned TIMEOUT = TIMEOUT_DEF,
  localparam int unsigned CW      = cnt_width(TIMEOUT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          expired
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_count <= '0;
    else if (clear)  r_count <= '0;
    else if (enable) r_count <= r_count + 1'b1;
  end

  assign count = r_count;

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
      // Firing on the cycle that would take the count to TIMEOUT aborts after exactly TIMEOUT waits.
      assign expired = enable && (r_count == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory bus between the IF fetch port and the MEM data port.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants on a tie instead of fixed MEM priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  output logic                  if_err,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ack,
  output logic                  mem_err,
  output logic                  bus_valid,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ready
);

  localparam int unsigned CW = cnt_width(TIMEOUT);

  arb_state_e    r_state;
  logic          w_busy;
  logic          w_if_req_m;
  logic          w_mem_req_m;
  logic          w_pick_mem;
  logic          w_pick_if;
  logic          w_cnt_en;
  logic          w_expired;
  logic [CW-1:0] w_wait_cnt;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  grant_e r_last_grant;
`endif

  always_comb begin
    w_busy      = (r_state == BUSY_IF) || (r_state == BUSY_MEM);
    // A port being acked this cycle still shows its old req; ignore it to avoid a stale re-grant.
    w_if_req_m  = if_req  && !if_ack;
    w_mem_req_m = mem_req && !mem_ack;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    w_pick_mem  = w_mem_req_m && (!w_if_req_m || (r_last_grant == GNT_IF));
`else
    w_pick_mem  = w_mem_req_m;
`endif
    w_pick_if   = w_if_req_m && !w_pick_mem;
    // Saturate instead of wrapping, which only matters with the timeout disabled.
    w_cnt_en    = w_busy && !bus_ready && (w_wait_cnt != '1);
  end

  arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (r_state == IDLE),
    .enable  (w_cnt_en),
    .count   (w_wait_cnt),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      if_rdata  <= '0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      mem_rdata <= '0;
      mem_ack   <= 1'b0;
      mem_err   <= 1'b0;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_last_grant <= GNT_IF;
`endif
    end else begin
      if_ack  <= 1'b0;
      if_err  <= 1'b0;
      mem_ack <= 1'b0;
      mem_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_mem) begin
            bus_valid <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
            r_state   <= BUSY_MEM;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_grant <= GNT_MEM;
`endif
          end else if (w_pick_if) begin
            bus_valid <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
            r_state   <= BUSY_IF;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_grant <= GNT_IF;
`endif
          end
        end
        BUSY_IF, BUSY_MEM: begin
          if (bus_ready || w_expired) begin
            bus_valid <= 1'b0;
            r_state   <= IDLE;
            if (r_state == BUSY_MEM) begin
              mem_ack   <= 1'b1;
              mem_err   <= !bus_ready;
              mem_rdata <= bus_ready ? bus_rdata : '0;
            end else begin
              if_ack    <= 1'b1;
              if_err    <= !bus_ready;
              if_rdata  <= bus_ready ? bus_rdata : '0;
            end
          end
        end
        default: begin
          bus_valid <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: main instance with TIMEOUT=4, second with TIMEOUT=0.
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit TIE2_MEM_FIRST = 1'b0;
`else
  localparam bit TIE2_MEM_FIRST = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack, if_err;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ack, mem_err;
  logic        bus_valid, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ready = 1'b0;

  logic        z_if_req = 1'b0;
  logic [31:0] z_if_addr = '0;
  logic [31:0] z_if_rdata;
  logic        z_if_ack, z_if_err;
  logic        z_mem_req = 1'b0;
  logic        z_mem_we = 1'b0;
  logic [31:0] z_mem_addr = '0;
  logic [31:0] z_mem_wdata = '0;
  logic [31:0] z_mem_rdata;
  logic        z_mem_ack, z_mem_err;
  logic        z_bus_valid, z_bus_we;
  logic [31:0] z_bus_addr, z_bus_wdata;
  logic [31:0] z_bus_rdata = '0;
  logic        z_bus_ready = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .if_req(z_if_req), .if_addr(z_if_addr), .if_rdata(z_if_rdata), .if_ack(z_if_ack), .if_err(z_if_err),
    .mem_req(z_mem_req), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
    .mem_rdata(z_mem_rdata), .mem_ack(z_mem_ack), .mem_err(z_mem_err),
    .bus_valid(z_bus_valid), .bus_we(z_bus_we), .bus_addr(z_bus_addr), .bus_wdata(z_bus_wdata),
    .bus_rdata(z_bus_rdata), .bus_ready(z_bus_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both ports request together; the first winner is acked in cycle 2, the loser granted then.
  task automatic tie(input bit mem_first, input logic [31:0] d1, input logic [31:0] d2, input string nm);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_3000;
    if_req  = 1'b1; if_addr = 32'h0000_0400;
    bus_ready = 1'b1; bus_rdata = d1;
    tick();
    check({nm, "_g1_valid"}, 32'(bus_valid), 32'd1);
    check({nm, "_g1_addr"}, bus_addr, mem_first ? 32'h0000_3000 : 32'h0000_0400);
    tick();
    check({nm, "_ack1"}, 32'(mem_first ? mem_ack : if_ack), 32'd1);
    check({nm, "_ack1_other"}, 32'(mem_first ? if_ack : mem_ack), 32'd0);
    check({nm, "_rdata1"}, mem_first ? mem_rdata : if_rdata, d1);
    check({nm, "_ack1_valid"}, 32'(bus_valid), 32'd0);
    if (mem_first) mem_req = 1'b0; else if_req = 1'b0;
    bus_rdata = d2;
    tick();
    check({nm, "_g2_valid"}, 32'(bus_valid), 32'd1);
    check({nm, "_g2_addr"}, bus_addr, mem_first ? 32'h0000_0400 : 32'h0000_3000);
    check({nm, "_g2_noack"}, 32'({if_ack, mem_ack}), 32'd0);
    tick();
    check({nm, "_ack2"}, 32'(mem_first ? if_ack : mem_ack), 32'd1);
    check({nm, "_ack2_other"}, 32'(mem_first ? mem_ack : if_ack), 32'd0);
    check({nm, "_rdata2"}, mem_first ? if_rdata : mem_rdata, d2);
    if_req = 1'b0; mem_req = 1'b0; bus_ready = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus_valid), 32'd0);
    check("rst_acks", 32'({if_ack, mem_ack, if_err, mem_err}), 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    rst = 1'b1;
    tick();

    // Zero-wait IF fetch
    if_req = 1'b1; if_addr = 32'h0000_0100;
    tick();
    check("if_c1_valid", 32'(bus_valid), 32'd1);
    check("if_c1_addr", bus_addr, 32'h0000_0100);
    check("if_c1_we", 32'(bus_we), 32'd0);
    check("if_c1_noack", 32'(if_ack), 32'd0);
    bus_ready = 1'b1; bus_rdata = 32'h2402_000A;
    tick();
    check("if_c2_ack", 32'(if_ack), 32'd1);
    check("if_c2_rdata", if_rdata, 32'h2402_000A);
    check("if_c2_err", 32'(if_err), 32'd0);
    check("if_c2_valid", 32'(bus_valid), 32'd0);
    if_req = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
    tick();
    check("if_c3_ack_pulse", 32'(if_ack), 32'd0);
    check("if_c3_rdata_hold", if_rdata, 32'h2402_000A);

    // First tie: MEM wins in both configurations
    tie(1'b1, 32'h1111_1111, 32'h2222_2222, "tie1");

    // MEM write with three wait states
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_2000; mem_wdata = 32'hDEAD_BEEF;
    for (int unsigned c = 1; c <= 4; c++) begin
      tick();
      check("wr_valid", 32'(bus_valid), 32'd1);
      check("wr_we", 32'(bus_we), 32'd1);
      check("wr_addr", bus_addr, 32'h0000_2000);
      check("wr_wdata", bus_wdata, 32'hDEAD_BEEF);
      check("wr_noack", 32'(mem_ack), 32'd0);
    end
    bus_ready = 1'b1;
    tick();
    check("wr_ack", 32'(mem_ack), 32'd1);
    check("wr_err", 32'(mem_err), 32'd0);
    check("wr_done_valid", 32'(bus_valid), 32'd0);
    mem_req = 1'b0; mem_we = 1'b0; bus_ready = 1'b0;
    tick();
    check("wr_ack_pulse", 32'(mem_ack), 32'd0);

    // Second tie: last grant was MEM
    tie(TIE2_MEM_FIRST, 32'h3333_3333, 32'h4444_4444, "tie2");

    // Timeout abort after 4 wait cycles
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_5000;
    for (int unsigned c = 1; c <= 4; c++) begin
      tick();
      check("to_valid", 32'(bus_valid), 32'd1);
      check("to_noack", 32'(mem_ack), 32'd0);
    end
    tick();
    check("to_drop_valid", 32'(bus_valid), 32'd0);
    check("to_ack", 32'(mem_ack), 32'd1);
    check("to_err", 32'(mem_err), 32'd1);
    check("to_rdata", mem_rdata, 32'd0);
    mem_req = 1'b0;
    tick();
    check("to_ack_pulse", 32'({mem_ack, mem_err}), 32'd0);

    // Normal service after a timeout
    mem_req = 1'b1; mem_addr = 32'h0000_5004;
    bus_ready = 1'b1; bus_rdata = 32'hCAFE_0001;
    tick();
    check("rec_valid", 32'(bus_valid), 32'd1);
    check("rec_addr", bus_addr, 32'h0000_5004);
    tick();
    check("rec_ack", 32'(mem_ack), 32'd1);
    check("rec_err", 32'(mem_err), 32'd0);
    check("rec_rdata", mem_rdata, 32'hCAFE_0001);
    mem_req = 1'b0; bus_ready = 1'b0;
    tick();

    // Asynchronous reset while BUSY_IF
    if_req = 1'b1; if_addr = 32'h0000_0600;
    tick();
    check("rb_valid", 32'(bus_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("ra_valid", 32'(bus_valid), 32'd0);
    check("ra_acks", 32'({if_ack, mem_ack}), 32'd0);
    @(posedge clk);
    #1;
    check("ra_hold_valid", 32'(bus_valid), 32'd0);
    #1 rst = 1'b1;
    tick();
    check("rr_valid", 32'(bus_valid), 32'd1);
    check("rr_addr", bus_addr, 32'h0000_0600);
    check("rr_noack", 32'(if_ack), 32'd0);
    bus_ready = 1'b1; bus_rdata = 32'hABCD_0600;
    tick();
    check("rr_ack", 32'(if_ack), 32'd1);
    check("rr_rdata", if_rdata, 32'hABCD_0600);
    if_req = 1'b0; bus_ready = 1'b0;
    tick();

    // TIMEOUT=0 instance never aborts
    z_if_req = 1'b1; z_if_addr = 32'h0000_0700; z_bus_ready = 1'b0;
    tick();
    check("t0_addr", z_bus_addr, 32'h0000_0700);
    for (int unsigned c = 0; c < 100; c++) begin
      tick();
      check("t0_valid", 32'(z_bus_valid), 32'd1);
      check("t0_noack", 32'({z_if_ack, z_if_err}), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
